blk_4bfc00: RTL and testbench
=============================

// Module: encoder_layer_1_attention_self_value_weight_replay_buffer
// PURPOSE
//  Sits directly downstream of the value-weight source stream. Captures one full weight
//  pass (DEPTH beats) into local registers, then replays it REPEAT times to the value
//  linear stage, one pass per sequence token. The weight ROM is therefore read once per
//  tile, not once per token. After the last replay it returns to capture the next tile.
// PARAMETERS
//  WEIGHT_PRECISION_0        16  bits per weight element
//  WEIGHT_TENSOR_SIZE_DIM_0  32  elements per full weight pass
//  WEIGHT_PARALLELISM_DIM_0   1  elements per beat, dim 0
//  WEIGHT_PARALLELISM_DIM_1   1  elements per beat, dim 1
//  REPEAT                     4  replays per captured pass (>=1)
//  DEPTH  TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0  beats per pass (derived, >=1)
//  PAR    PARALLELISM_DIM_0*PARALLELISM_DIM_1  elements per beat (derived)
// PORTS
//  clk             in   1                       single clock, rising edge
//  rst             in   1                       reset, asynchronous assert, active-low
//  data_in         in   [PRECISION_0-1:0] x PAR weight beat from source
//  data_in_valid   in   1                       source beat valid
//  data_in_ready   out  1                       buffer accepts beat
//  data_out        out  [PRECISION_0-1:0] x PAR weight beat to linear stage
//  data_out_valid  out  1                       replay beat valid
//  data_out_ready  in   1                       consumer accepts beat
//  data_out_last   out  1                       beat is DEPTH-1 of replay REPEAT-1
// BEHAVIOUR
//  - Reset (rst=0, async): state=FILL, wr_ptr=0, rd_ptr=0, rep_cnt=0,
//    data_in_ready=0 while rst is asserted, data_out_valid=0, data_out_last=0,
//    data_out=0. Storage contents are not reset. A reset mid-pass discards the partial
//    fill or replay. The next fill restarts at beat 0.
//  - FSM FILL: data_in_ready=1 and data_out_valid=0.
//    - Each handshake (valid&ready) writes mem[wr_ptr]<=data_in, then wr_ptr++.
//    - The handshake at wr_ptr==DEPTH-1 sets wr_ptr<=0, rd_ptr<=0, rep_cnt<=0,
//      state<=REPLAY.
//    - Input gaps (valid=0) stall the fill without loss.
//  - FSM REPLAY: data_in_ready=0, so source beats are held upstream and never dropped.
//    - data_out_valid=1. data_out=mem[rd_ptr] as a combinational read of the registers.
//    - data_out_last=(rd_ptr==DEPTH-1)&&(rep_cnt==REPEAT-1).
//    - On handshake: if rd_ptr==DEPTH-1, then rd_ptr<=0 and rep_cnt++. Otherwise rd_ptr++.
//    - A handshake while data_out_last=1 sets state<=FILL and rep_cnt<=0.
//  - Latency: the first replay beat is valid in the cycle after the final fill beat is
//    accepted. A full tile costs DEPTH fill cycles plus DEPTH*REPEAT replay cycles,
//    with no bubbles under full throughput.
//  - Backpressure: while data_out_valid=1 and data_out_ready=0, data_out,
//    data_out_valid and data_out_last hold stable. Pointers hold.
//  - Data is never modified. Element j of a beat occupies the same lane on output as
//    on input.
//  - Degenerate cases:
//    - DEPTH=1: every accepted beat goes straight to REPLAY.
//    - REPEAT=1: the buffer is a store-and-forward of one pass.
//    - Counter widths: $clog2(DEPTH)+1 and $clog2(REPEAT)+1 bits.
//  - No simultaneous fill and replay in any state. The ready and valid sides are
//    mutually exclusive by construction.
// TESTING
//  1 DEPTH=32,REPEAT=4, feed beats 0x0001..0x0020 back-to-back, out_ready=1 ->
//    128 out beats 0x0001..0x0020 x4, last=1 only on beat 128 and it carries 0x0020,
//    in_ready high again the next cycle.
//  2 Same fill, out_ready toggling 1/0 each cycle -> sequence identical to test 1,
//    data_out stable across every stalled cycle, no beat duplicated or skipped.
//  3 Hold in_valid=1 throughout the replay, with new values 0x1xxx -> in_ready=0 for the
//    whole replay, none of 0x1xxx appears in the output, the second tile's replay
//    carries 0x1xxx.
//  4 Assert rst low at out beat 50 of test 1, release it, then refill with 0x0101.. ->
//    valid=0 in the cycle rst falls, the replay restarts from beat 0 of the new data,
//    no old data is output.
//  5 DEPTH=1,REPEAT=1, feed 0xAAAA, 0xBBBB -> out 0xAAAA with last=1, then 0xBBBB with
//    last=1; in_ready alternates 1/0 under full throughput.
//  6 Random in_valid gaps (30%) during fill -> replay content matches the capture order.

Source files
------------

// File: rtl/blk_4bfc00.sv
// Weight replay buffer: captures one full weight pass from the source stream, then
// replays it REPEAT times to the value linear stage before accepting the next tile.
module blk_4bfc00 #(
  parameter int WEIGHT_PRECISION_0       = 16,
  parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter int REPEAT                   = 4,
  localparam int PAR = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PAR-1:0][WEIGHT_PRECISION_0-1:0] data_in,
  input  logic                                   data_in_valid,
  output logic                                   data_in_ready,
  output logic [PAR-1:0][WEIGHT_PRECISION_0-1:0] data_out,
  output logic                                   data_out_valid,
  input  logic                                   data_out_ready,
  output logic                                   data_out_last
);

  localparam int DEPTH = WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int RW    = $clog2(REPEAT) + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = 1 << AW;

  localparam logic [PW-1:0] LAST_BEAT = PW'(DEPTH - 1);
  localparam logic [RW-1:0] LAST_REP  = RW'(REPEAT - 1);

  typedef enum logic {FILL, REPLAY} state_t;
  typedef logic [PAR-1:0][WEIGHT_PRECISION_0-1:0] beat_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [RW-1:0] rep_cnt;
  logic          in_ready;
  logic          out_valid;
  beat_t         mem [MEM_N];

  logic in_fire;
  logic out_fire;
  logic at_last_beat;

  assign in_fire      = data_in_valid && in_ready;
  assign out_fire     = out_valid && data_out_ready;
  assign at_last_beat = (rd_ptr == LAST_BEAT);

  assign data_in_ready  = in_ready;
  assign data_out_valid = out_valid;
  assign data_out_last  = out_valid && at_last_beat && (rep_cnt == LAST_REP);
  // Storage is not cleared, so gate the read to present zero outside REPLAY.
  assign data_out       = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // NOTE: storage has no reset; clearing it would only cost flops, since every
  // entry is rewritten by a complete fill before it can be replayed.
  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // NOTE: every register here is updated with <= so all reads see the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rep_cnt   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            if (wr_ptr == LAST_BEAT) begin
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              rep_cnt   <= '0;
              state     <= REPLAY;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        REPLAY: begin
          if (out_fire) begin
            if (data_out_last) begin
              state     <= FILL;
              rd_ptr    <= '0;
              rep_cnt   <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end else if (at_last_beat) begin
              rd_ptr  <= '0;
              rep_cnt <= rep_cnt + 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_4bfc00.sv
// Directed bench for the weight replay buffer: a 32x4 instance for streaming,
// backpressure, held-off source, reset and gapped fill, plus a 1x1 degenerate instance.
module tb_blk_4bfc00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_in, a_out;
  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_in, b_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  blk_4bfc00 #(
    .WEIGHT_PRECISION_0(16), .WEIGHT_TENSOR_SIZE_DIM_0(32),
    .WEIGHT_PARALLELISM_DIM_0(1), .WEIGHT_PARALLELISM_DIM_1(1), .REPEAT(4)
  ) dut_a (
    .clk(clk), .rst(a_rst),
    .data_in(a_in), .data_in_valid(a_in_valid), .data_in_ready(a_in_ready),
    .data_out(a_out), .data_out_valid(a_out_valid), .data_out_ready(a_out_ready),
    .data_out_last(a_out_last)
  );

  blk_4bfc00 #(
    .WEIGHT_PRECISION_0(16), .WEIGHT_TENSOR_SIZE_DIM_0(1),
    .WEIGHT_PARALLELISM_DIM_0(1), .WEIGHT_PARALLELISM_DIM_1(1), .REPEAT(1)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .data_in(b_in), .data_in_valid(b_in_valid), .data_in_ready(b_in_ready),
    .data_out(b_out), .data_out_valid(b_out_valid), .data_out_ready(b_out_ready),
    .data_out_last(b_out_last)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Deliver 32 beats base..base+31, optionally with random valid gaps.
  task automatic fill_a(input logic [15:0] base, input int gap_pct);
    int  i     = 0;
    int  guard = 0;
    logic hs;
    while (i < 32 && guard < 2000) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        a_in_valid = 1'b0;
      end else begin
        a_in_valid = 1'b1;
        a_in       = base + 16'(i);
      end
      hs = a_in_valid && a_in_ready;
      step();
      if (hs) i++;
      guard++;
    end
    a_in_valid = 1'b0;
    check("fill_done", i, 32);
    check("first_valid_latency", a_out_valid, 1);
  endtask

  // Consume n replay beats; expected beat k is base + (k mod 32), last only on beat 127.
  task automatic drain_a(input logic [15:0] base, input bit toggle, input bit hold_in, input int n);
    int          k      = 0;
    int          cyc    = 0;
    bit          stalled = 1'b0;
    logic [15:0] held;
    logic        held_last;
    if (hold_in) begin
      a_in_valid = 1'b1;
      a_in       = 16'h1ABC;
    end
    while (k < n && cyc < 1000) begin
      a_out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        check("stall_data_hold", a_out, held);
        check("stall_last_hold", a_out_last, held_last);
      end
      check("replay_valid", a_out_valid, 1);
      if (hold_in) check("in_ready_low_in_replay", a_in_ready, 0);
      stalled = 1'b0;
      if (a_out_valid && a_out_ready) begin
        check("replay_data", a_out, base + 16'(k % 32));
        check("replay_last", a_out_last, (k == 127));
        k++;
      end else if (a_out_valid) begin
        stalled   = 1'b1;
        held      = a_out;
        held_last = a_out_last;
      end
      step();
      cyc++;
    end
    check("drain_done", k, n);
    if (n == 128) begin
      check("in_ready_after_tile", a_in_ready, 1);
      check("valid_low_after_tile", a_out_valid, 0);
    end
  endtask

  initial begin
    a_rst = 1'b0; b_rst = 1'b0;
    a_in = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    step();
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_last", a_out_last, 0);
    check("rst_out_data", a_out, 0);
    a_rst = 1'b1; b_rst = 1'b1;
    step();
    check("in_ready_after_rst", a_in_ready, 1);

    // Test 1: back-to-back fill and full-rate replay.
    fill_a(16'h0001, 0);
    drain_a(16'h0001, 1'b0, 1'b0, 128);

    // Test 2: consumer ready toggling every cycle.
    fill_a(16'h0001, 0);
    drain_a(16'h0001, 1'b1, 1'b0, 128);

    // Test 3: source keeps offering beats during replay; the next tile carries 0x1xxx.
    fill_a(16'h0001, 0);
    drain_a(16'h0001, 1'b0, 1'b1, 128);
    fill_a(16'h1001, 0);
    drain_a(16'h1001, 1'b0, 1'b0, 128);

    // Test 4: reset in the middle of a replay, then refill with new data.
    fill_a(16'h0001, 0);
    drain_a(16'h0001, 1'b0, 1'b0, 50);
    a_rst = 1'b0;
    #1;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_last", a_out_last, 0);
    check("midrst_data", a_out, 0);
    step();
    check("midrst_in_ready", a_in_ready, 0);
    a_rst = 1'b1;
    step();
    check("postrst_in_ready", a_in_ready, 1);
    check("postrst_valid", a_out_valid, 0);
    fill_a(16'h0101, 0);
    drain_a(16'h0101, 1'b0, 1'b0, 128);

    // Test 6: random source gaps during fill.
    fill_a(16'h2001, 30);
    drain_a(16'h2001, 1'b0, 1'b0, 128);

    // Test 5: DEPTH=1, REPEAT=1 store-and-forward.
    b_out_ready = 1'b1;
    check("b_ready0", b_in_ready, 1);
    check("b_valid0", b_out_valid, 0);
    b_in = 16'hAAAA; b_in_valid = 1'b1;
    step();
    check("b_ready1", b_in_ready, 0);
    check("b_valid1", b_out_valid, 1);
    check("b_data1", b_out, 16'hAAAA);
    check("b_last1", b_out_last, 1);
    b_in = 16'hBBBB;
    step();
    check("b_ready2", b_in_ready, 1);
    check("b_valid2", b_out_valid, 0);
    step();
    check("b_ready3", b_in_ready, 0);
    check("b_valid3", b_out_valid, 1);
    check("b_data3", b_out, 16'hBBBB);
    check("b_last3", b_out_last, 1);
    b_in_valid = 1'b0;
    step();
    check("b_ready4", b_in_ready, 1);
    check("b_valid4", b_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
